register_array: RTL and testbench

// - Hardware max-priority queue built as a sorted shift-register array; slot 0 always holds the largest stored value.
// - Supports enqueue, dequeue and replace (pop max + push new) in one clock.
// - Leaf block for schedulers/search engines that need O(1) access to the current maximum.

---
 rtl/register_array_pkg.sv | 21 ++
 rtl/register_array_cell.sv | 78 +++++++
 rtl/register_array.sv | 152 +++++++++++++++
 tb/tb_register_array.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/register_array_pkg.sv
// -----------------------------------------------------------------------------
// register_array_pkg
// Shared types and helpers for the sorted max-priority queue (register_array).
//   op_e        : per-cycle operation decoded from {i_wrt, i_read}
//   count_width : bits needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package register_array_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2,
    OP_REPL = 2'd3
  } op_e;

  // Occupancy runs 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/register_array_cell.sv
// -----------------------------------------------------------------------------
// register_array_cell
// Next-value logic for one slot of the sorted queue. Purely combinational;
// the slot register itself lives in the top so the whole array resets together.
// Ports:
//   own_val/own_valid   : this slot's stored value and occupancy flag
//   prev_val/prev_valid : slot toward the head (unused when HEAD=1)
//   next_val/next_valid : slot toward the tail (0/invalid beyond the last slot)
//   i_data              : key being inserted
//   op                  : effective operation (already qualified by full/empty)
//   next_slot           : value this slot takes on the next rising edge
// Parameter HEAD marks slot 0, which has no neighbour toward the head.
// -----------------------------------------------------------------------------
module register_array_cell
  import register_array_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter bit HEAD       = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] own_val,
  input  logic [DATA_WIDTH-1:0] prev_val,
  input  logic [DATA_WIDTH-1:0] next_val,
  input  logic                  own_valid,
  input  logic                  prev_valid,
  input  logic                  next_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  op_e                   op,
  output logic [DATA_WIDTH-1:0] next_slot
);

  logic own_ge_s;
  logic prev_ge_s;
  logic next_ge_s;

  // Slot selection. Because valid slots are sorted descending, the entries
  // that are >= i_data form a prefix; each cell only needs its neighbours'
  // comparisons to know whether it sits before, at, or after the insert point.
  always_comb begin
    own_ge_s  = own_valid && (own_val >= i_data);
    prev_ge_s = HEAD ? 1'b1 : (prev_valid && (prev_val >= i_data));
    next_ge_s = next_valid && (next_val >= i_data);
    next_slot = own_val;
    case (op)
      OP_NOP: begin
        next_slot = own_val;
      end
      OP_ENQ: begin
        // Before insert point: keep. At it: take new key. After: shift tailward.
        if (own_ge_s) begin
          next_slot = own_val;
        end else if (prev_ge_s) begin
          next_slot = i_data;
        end else begin
          next_slot = prev_val;
        end
      end
      OP_DEQ: begin
        // Invalid slots hold 0, so the tail naturally fills with 0.
        next_slot = next_val;
      end
      OP_REPL: begin
        // Head removal shifts everything headward while the insert shifts
        // tailward; beyond the insert point the two cancel and the slot keeps.
        if (next_ge_s) begin
          next_slot = next_val;
        end else if (HEAD || own_ge_s) begin
          next_slot = i_data;
        end else begin
          next_slot = own_val;
        end
      end
      default: begin
        next_slot = own_val;
      end
    endcase
  end

endmodule

// File: rtl/register_array.sv
// -----------------------------------------------------------------------------
// register_array
// Max-priority queue as a sorted shift-register array; slot 0 always holds the
// largest stored unsigned key. ENQ, DEQ and REPL (pop max + push) complete in
// one clock, back-to-back, with no stall.
// Ports:
//   CLK     : clock, rising edge
//   RSTn    : asynchronous reset, ACTIVE HIGH despite the name (1 clears queue)
//   i_wrt   : enqueue request (replace when i_read also high)
//   i_read  : dequeue request (replace when i_wrt also high)
//   i_data  : key to insert, sampled when i_wrt=1
//   o_full  : occupancy == QUEUE_SIZE
//   o_empty : occupancy == 0
//   o_data  : current maximum (slot 0), 0 when empty, straight from register
//   o_count : occupancy, present only when REGISTER_ARRAY_COUNT_EN is defined
// Configuration macro: REGISTER_ARRAY_COUNT_EN adds the o_count port.
// -----------------------------------------------------------------------------
module register_array
  import register_array_pkg::*;
#(
  parameter int QUEUE_SIZE = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef REGISTER_ARRAY_COUNT_EN
  ,
  output logic [count_width(QUEUE_SIZE)-1:0] o_count
`endif
);

  localparam int CW = count_width(QUEUE_SIZE);

  logic [DATA_WIDTH-1:0] slot_r      [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] slot_nxt_s  [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] prev_val_s  [QUEUE_SIZE];
  logic [DATA_WIDTH-1:0] next_val_s  [QUEUE_SIZE];
  logic [QUEUE_SIZE-1:0] valid_s;
  logic [QUEUE_SIZE-1:0] prev_valid_s;
  logic [QUEUE_SIZE-1:0] next_valid_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  op_e                   req_op_s;
  op_e                   eff_op_s;

  assign o_full  = (count_r == CW'(QUEUE_SIZE));
  assign o_empty = (count_r == {CW{1'b0}});
  assign o_data  = slot_r[0];

`ifdef REGISTER_ARRAY_COUNT_EN
  assign o_count = count_r;
`endif

  // Decode the request, then qualify it: ENQ on full and DEQ on empty become
  // NOP, and REPL on empty degenerates to a plain ENQ.
  always_comb begin
    case ({i_wrt, i_read})
      2'b00:   req_op_s = OP_NOP;
      2'b10:   req_op_s = OP_ENQ;
      2'b01:   req_op_s = OP_DEQ;
      2'b11:   req_op_s = OP_REPL;
      default: req_op_s = OP_NOP;
    endcase
    eff_op_s = OP_NOP;
    case (req_op_s)
      OP_NOP: eff_op_s = OP_NOP;
      OP_ENQ: begin
        if (o_full) eff_op_s = OP_NOP;
        else        eff_op_s = OP_ENQ;
      end
      OP_DEQ: begin
        if (o_empty) eff_op_s = OP_NOP;
        else         eff_op_s = OP_DEQ;
      end
      OP_REPL: begin
        if (o_empty) eff_op_s = OP_ENQ;
        else         eff_op_s = OP_REPL;
      end
      default: eff_op_s = OP_NOP;
    endcase
  end

  // Occupancy follows the qualified op; REPL leaves it unchanged.
  always_comb begin
    case (eff_op_s)
      OP_ENQ:  count_nxt_s = count_r + CW'(1'b1);
      OP_DEQ:  count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_slot
      assign valid_s[gi] = (count_r > CW'(gi));

      if (gi == 0) begin : g_head
        assign prev_val_s[gi]   = {DATA_WIDTH{1'b0}};
        assign prev_valid_s[gi] = 1'b0;
      end else begin : g_mid_prev
        assign prev_val_s[gi]   = slot_r[gi-1];
        assign prev_valid_s[gi] = valid_s[gi-1];
      end

      if (gi == QUEUE_SIZE - 1) begin : g_tail
        assign next_val_s[gi]   = {DATA_WIDTH{1'b0}};
        assign next_valid_s[gi] = 1'b0;
      end else begin : g_mid_next
        assign next_val_s[gi]   = slot_r[gi+1];
        assign next_valid_s[gi] = valid_s[gi+1];
      end

      register_array_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .HEAD       (gi == 0)
      ) u_cell (
        .own_val    (slot_r[gi]),
        .prev_val   (prev_val_s[gi]),
        .next_val   (next_val_s[gi]),
        .own_valid  (valid_s[gi]),
        .prev_valid (prev_valid_s[gi]),
        .next_valid (next_valid_s[gi]),
        .i_data     (i_data),
        .op         (eff_op_s),
        .next_slot  (slot_nxt_s[gi])
      );
    end
  endgenerate

  // Slot array and occupancy registers; reset clears every slot so that
  // unoccupied slots always read as 0.
  always_ff @(posedge CLK or posedge RSTn) begin
    if (RSTn) begin
      for (int k = 0; k < QUEUE_SIZE; k++) begin
        slot_r[k] <= {DATA_WIDTH{1'b0}};
      end
      count_r <= {CW{1'b0}};
    end else begin
      for (int k = 0; k < QUEUE_SIZE; k++) begin
        slot_r[k] <= slot_nxt_s[k];
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_register_array.sv
// -----------------------------------------------------------------------------
// tb_register_array
// Self-checking bench for register_array. A reference priority queue is kept
// as a SystemVerilog queue re-sorted descending after every insert; every
// operation's outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_register_array;

  localparam int QS = 64;
  localparam int DW = 16;

  logic          CLK;
  logic          RSTn;
  logic          i_wrt;
  logic          i_read;
  logic [DW-1:0] i_data;
  logic          o_full;
  logic          o_empty;
  logic [DW-1:0] o_data;
`ifdef REGISTER_ARRAY_COUNT_EN
  logic [6:0]    o_count;
`endif

  int unsigned model_q[$];
  int          errors = 0;
  int          checks = 0;

  register_array #(
    .QUEUE_SIZE (QS),
    .DATA_WIDTH (DW)
  ) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_wrt   (i_wrt),
    .i_read  (i_read),
    .i_data  (i_data),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_data  (o_data)
`ifdef REGISTER_ARRAY_COUNT_EN
    ,
    .o_count (o_count)
`endif
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour: the queue as a sorted multiset.
  task automatic model_apply(input bit w, input bit r, input int unsigned d);
    if (w && r) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
      model_q.push_back(d);
      model_q.rsort();
    end else if (w) begin
      if (model_q.size() < QS) begin
        model_q.push_back(d);
        model_q.rsort();
      end
    end else if (r) begin
      if (model_q.size() > 0) void'(model_q.pop_front());
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned exp_max;
    exp_max = (model_q.size() > 0) ? model_q[0] : 32'd0;
    check({tag, "_data"},  o_data, exp_max);
    check({tag, "_full"},  o_full, (model_q.size() == QS) ? 32'd1 : 32'd0);
    check({tag, "_empty"}, o_empty, (model_q.size() == 0) ? 32'd1 : 32'd0);
    check({tag, "_nox"},   $isunknown({o_data, o_full, o_empty}) ? 32'd1 : 32'd0, 32'd0);
`ifdef REGISTER_ARRAY_COUNT_EN
    check({tag, "_count"}, o_count, model_q.size());
`endif
  endtask

  task automatic do_op(input bit w, input bit r, input int unsigned d, input string tag);
    i_wrt  = w;
    i_read = r;
    i_data = d[DW-1:0];
    @(posedge CLK);
    #1;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    model_apply(w, r, d);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    RSTn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b0;
    model_q.delete();
  endtask

  initial begin
    int unsigned prev_max;
    int unsigned v;
    bit          w;
    bit          r;

    RSTn   = 1'b1;
    i_wrt  = 1'b0;
    i_read = 1'b0;
    i_data = 16'd0;
    do_reset();

    // Reset then idle.
    do_op(1'b0, 1'b0, 32'd0, "idle");
    check("rst_data", o_data, 32'd0);
    check("rst_empty", o_empty, 32'd1);
    check("rst_full", o_full, 32'd0);

    // Small directed sequence.
    do_op(1'b1, 1'b0, 32'd5,   "enq5");
    do_op(1'b1, 1'b0, 32'd900, "enq900");
    do_op(1'b1, 1'b0, 32'd17,  "enq17");
    check("max900", o_data, 32'd900);
    do_op(1'b0, 1'b1, 32'd0, "deq_a");
    check("deq17", o_data, 32'd17);
    do_op(1'b0, 1'b1, 32'd0, "deq_b");
    check("deq5", o_data, 32'd5);
    do_op(1'b0, 1'b1, 32'd0, "deq_c");
    check("deq_empty", o_empty, 32'd1);
    check("deq_zero", o_data, 32'd0);

    // DEQ on empty is ignored.
    do_op(1'b0, 1'b1, 32'd0, "deq_on_empty");

    // Fill with random keys, overflow, then drain in descending order.
    for (int i = 0; i < QS; i++) begin
      do_op(1'b1, 1'b0, $urandom_range(1024, 0), "fill");
    end
    check("filled_full", o_full, 32'd1);
    do_op(1'b1, 1'b0, 32'd1024, "enq_on_full");
    prev_max = o_data;
    for (int i = 0; i < QS; i++) begin
      do_op(1'b0, 1'b1, 32'd0, "drain");
      check("drain_desc", (o_data <= prev_max) ? 32'd1 : 32'd0, 32'd1);
      prev_max = o_data;
    end
    check("drained_empty", o_empty, 32'd1);

    // Full queue with max 1000, then REPL with a small key.
    do_op(1'b1, 1'b0, 32'd1000, "enq1000");
    for (int i = 1; i < QS; i++) begin
      do_op(1'b1, 1'b0, $urandom_range(999, 0), "fill2");
    end
    check("max1000", o_data, 32'd1000);
    do_op(1'b1, 1'b1, 32'd3, "repl_full");
    check("repl_stays_full", o_full, 32'd1);
    do_op(1'b1, 1'b1, 32'd1023, "repl_big");
    check("repl_big_max", o_data, 32'd1023);

    // REPL on empty acts as ENQ.
    do_reset();
    do_op(1'b1, 1'b1, 32'd42, "repl_empty");
    check("repl_empty_data", o_data, 32'd42);
    check("repl_empty_ne", o_empty, 32'd0);
    do_op(1'b0, 1'b1, 32'd0, "repl_empty_deq");
    check("repl_count1", o_empty, 32'd1);

    // Random mix against the model, starting partly filled.
    for (int i = 0; i < 20; i++) begin
      do_op(1'b1, 1'b0, $urandom_range(65535, 0), "prefill");
    end
    for (int i = 0; i < 100; i++) begin
      w = $urandom_range(1, 0) == 1;
      r = $urandom_range(1, 0) == 1;
      v = $urandom_range(65535, 0);
      do_op(w, r, v, "mix");
    end

    // Asynchronous reset in the middle of a pending enqueue.
    if (model_q.size() == 0) do_op(1'b1, 1'b0, 32'd77, "pre_rst");
    i_wrt  = 1'b1;
    i_data = 16'd500;
    #2;
    RSTn = 1'b1;
    #1;
    check("async_rst_empty", o_empty, 32'd1);
    check("async_rst_data", o_data, 32'd0);
    @(posedge CLK);
    #1;
    check("rst_discard_empty", o_empty, 32'd1);
    i_wrt = 1'b0;
    RSTn  = 1'b0;
    model_q.delete();
    do_op(1'b0, 1'b0, 32'd0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
